// File: rtl/bsg_mesh_traffic_pkg.sv
// Shared types for the mesh traffic node: packet layout macro, FSM states
// and a saturating counter helper.
`define DECLARE_BSG_MESH_TRAFFIC_PKT_S(seq_w, y_w, x_w) \
  typedef struct packed { \
    logic [seq_w-1:0] seq; \
    logic [y_w-1:0]   src_y; \
    logic [x_w-1:0]   src_x; \
    logic [y_w-1:0]   dest_y; \
    logic [x_w-1:0]   dest_x; \
  } bsg_mesh_traffic_pkt_s

package bsg_mesh_traffic_pkg;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_send  = 2'd1,
    e_drain = 2'd2,
    e_done  = 2'd3
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bsg_mesh_traffic_checker.sv
// Receive side of a traffic node: consumes ejected packets, tracks the next
// expected sequence number per source and flags any ordering or routing fault.
module bsg_mesh_traffic_checker
  import bsg_mesh_traffic_pkg::*;
#(
  parameter  int x_cord_width_p = 2,
  parameter  int y_cord_width_p = 2,
  parameter  int num_x_p        = 4,
  parameter  int num_y_p        = 4,
  parameter  int seq_width_p    = 8,
  localparam int width_lp       = seq_width_p + 2*(y_cord_width_p + x_cord_width_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      clear_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic                      v_i,
  input  logic [width_lp-1:0]       data_i,
  input  logic                      consume_en_i,
  input  logic                      excess_chk_i,
  input  logic [31:0]               expected_i,
  output logic                      yumi_o,
  output logic                      error_o,
  output logic [31:0]               recv_count_o
);

  `DECLARE_BSG_MESH_TRAFFIC_PKT_S(seq_width_p, y_cord_width_p, x_cord_width_p);

  localparam int num_nodes_lp = num_x_p * num_y_p;
  localparam int idx_width_lp = (num_nodes_lp > 1) ? $clog2(num_nodes_lp) : 1;

  bsg_mesh_traffic_pkt_s   w_pkt;
  logic                    w_yumi;
  logic                    w_src_ok;
  logic                    w_dest_ok;
  logic                    w_seq_ok;
  logic                    w_excess;
  logic                    w_bad;
  logic [idx_width_lp-1:0] w_idx;

  logic [seq_width_p-1:0]  r_exp_seq [num_nodes_lp];
  logic                    r_error;
  logic [31:0]             r_recv;

  assign w_pkt     = data_i;
  assign w_yumi    = v_i & consume_en_i;
  assign w_src_ok  = (int'(w_pkt.src_x) < num_x_p) && (int'(w_pkt.src_y) < num_y_p);
  assign w_dest_ok = (w_pkt.dest_x == my_x_i) && (w_pkt.dest_y == my_y_i);
  assign w_idx     = idx_width_lp'(int'(w_pkt.src_y) * num_x_p + int'(w_pkt.src_x));
  assign w_seq_ok  = w_src_ok && (w_pkt.seq == r_exp_seq[w_idx]);
  // Anything consumed once the quota is met in DRAIN/DONE is surplus traffic.
  assign w_excess  = excess_chk_i && (r_recv == expected_i);
  assign w_bad     = !w_dest_ok || !w_src_ok || !w_seq_ok || w_excess;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      r_error <= 1'b0;
      r_recv  <= '0;
    end else if (w_yumi) begin
      r_recv <= sat_inc(r_recv);
      if (w_bad) r_error <= 1'b1;
    end
  end

  // NOTE: the sequence table is deliberately reset (and cleared on start) so a
  // new run never compares against stale per-source state.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      for (int i = 0; i < num_nodes_lp; i++) r_exp_seq[i] <= '0;
    end else if (w_yumi && w_src_ok) begin
      r_exp_seq[w_idx] <= r_exp_seq[w_idx] + seq_width_p'(1);
    end
  end

  assign yumi_o       = w_yumi;
  assign error_o      = r_error;
  assign recv_count_o = r_recv;

endmodule

// File: rtl/bsg_mesh_traffic_node.sv
// Mesh traffic node: injects all-to-all sweep or transpose traffic and
// checks its ejected packets via bsg_mesh_traffic_checker.
module bsg_mesh_traffic_node
  import bsg_mesh_traffic_pkg::*;
#(
  parameter  int x_cord_width_p = 2,
  parameter  int y_cord_width_p = 2,
  parameter  int num_x_p        = 4,
  parameter  int num_y_p        = 4,
  parameter  int seq_width_p    = 8,
  localparam int width_lp       = seq_width_p + 2*(y_cord_width_p + x_cord_width_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic                      start_i,
  input  logic                      mode_i,
  input  logic [seq_width_p-1:0]    rounds_i,
  input  logic                      consume_en_i,
  output logic                      v_o,
  output logic [width_lp-1:0]       data_o,
  input  logic                      ready_and_i,
  input  logic                      v_i,
  input  logic [width_lp-1:0]       data_i,
  output logic                      yumi_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic [31:0]               sent_count_o,
  output logic [31:0]               recv_count_o
);

  `DECLARE_BSG_MESH_TRAFFIC_PKT_S(seq_width_p, y_cord_width_p, x_cord_width_p);

  localparam int num_nodes_lp = num_x_p * num_y_p;
  localparam logic [x_cord_width_p-1:0] max_x_lp = x_cord_width_p'(num_x_p - 1);
  localparam logic [y_cord_width_p-1:0] max_y_lp = y_cord_width_p'(num_y_p - 1);

  state_e                    r_state;
  state_e                    w_state_n;
  state_e                    w_start_tgt;
  logic                      r_mode;
  logic [seq_width_p-1:0]    r_rounds;
  logic [seq_width_p-1:0]    r_round;
  logic [x_cord_width_p-1:0] r_dx;
  logic [y_cord_width_p-1:0] r_dy;
  logic [31:0]               r_expected;
  logic [31:0]               r_sent;

  logic                      w_send;
  logic                      w_drain;
  logic                      w_start;
  logic                      w_xfer;
  logic                      w_wrap_xy;
  logic                      w_last;
  logic                      w_tp_valid;
  logic [31:0]               w_expected_n;
  bsg_mesh_traffic_pkt_s     w_pkt;

  assign w_send  = (r_state == e_send);
  assign w_drain = (r_state == e_drain);
  // Start is only honoured from IDLE/DONE; a start while busy is dropped.
  assign w_start = start_i && !(w_send || w_drain);
  assign w_xfer  = w_send && ready_and_i;

  assign w_wrap_xy = (r_dx == max_x_lp) && (r_dy == max_y_lp);
  assign w_last    = (r_round == (r_rounds - seq_width_p'(1))) && (r_mode || w_wrap_xy);

  // In transpose mode only the node at (x=my_y, y=my_x) targets us.
  assign w_tp_valid   = (int'(my_y_i) < num_x_p) && (int'(my_x_i) < num_y_p);
  assign w_expected_n = mode_i ? (w_tp_valid ? 32'(rounds_i) : 32'd0)
                               : 32'(rounds_i) * 32'(num_nodes_lp);
  assign w_start_tgt  = (rounds_i != '0) ? e_send : e_done;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= e_idle;
      r_mode     <= 1'b0;
      r_rounds   <= '0;
      r_expected <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_start) begin
        r_mode     <= mode_i;
        r_rounds   <= rounds_i;
        r_expected <= w_expected_n;
      end
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      e_idle:  if (start_i) w_state_n = w_start_tgt;
      e_send:  if (w_xfer && w_last) w_state_n = e_drain;
      e_drain: if (recv_count_o >= r_expected) w_state_n = e_done;
      e_done:  if (start_i) w_state_n = w_start_tgt;
      default: w_state_n = e_idle;
    endcase
  end

  // Destination walk: dest_x fastest, then dest_y, then round.
  always_ff @(posedge clk_i) begin
    if (reset_i || w_start) begin
      r_round <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
    end else if (w_xfer) begin
      if (r_mode || w_wrap_xy) begin
        r_dx    <= '0;
        r_dy    <= '0;
        r_round <= r_round + seq_width_p'(1);
      end else if (r_dx == max_x_lp) begin
        r_dx <= '0;
        r_dy <= r_dy + y_cord_width_p'(1);
      end else begin
        r_dx <= r_dx + x_cord_width_p'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || w_start) r_sent <= '0;
    else if (w_xfer)        r_sent <= sat_inc(r_sent);
  end

  // Packet fields come only from registered state and static coordinates,
  // so data_o cannot move while a transfer is pending.
  always_comb begin
    w_pkt       = '0;
    w_pkt.seq   = r_round;
    w_pkt.src_y = my_y_i;
    w_pkt.src_x = my_x_i;
    if (r_mode) begin
      w_pkt.dest_x = x_cord_width_p'(my_y_i);
      w_pkt.dest_y = y_cord_width_p'(my_x_i);
    end else begin
      w_pkt.dest_x = r_dx;
      w_pkt.dest_y = r_dy;
    end
  end

  assign v_o          = w_send;
  assign data_o       = w_send ? w_pkt : '0;
  assign busy_o       = w_send || w_drain;
  assign done_o       = (r_state == e_done);
  assign sent_count_o = r_sent;

  bsg_mesh_traffic_checker #(
    .x_cord_width_p(x_cord_width_p),
    .y_cord_width_p(y_cord_width_p),
    .num_x_p       (num_x_p),
    .num_y_p       (num_y_p),
    .seq_width_p   (seq_width_p)
  ) u_checker (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clear_i     (w_start),
    .my_x_i      (my_x_i),
    .my_y_i      (my_y_i),
    .v_i         (v_i),
    .data_i      (data_i),
    .consume_en_i(consume_en_i),
    .excess_chk_i(w_drain || done_o),
    .expected_i  (r_expected),
    .yumi_o      (yumi_o),
    .error_o     (error_o),
    .recv_count_o(recv_count_o)
  );

endmodule
